// File: rtl/stepper_sequencer.sv
// stepper_sequencer: turns move commands into a 4-phase coil pattern for one
// stepper motor, tracks absolute position in half-steps, holds torque after a
// move and then de-energizes the coils. drive_out feeds step_drive drive_in.
module stepper_sequencer #(
  parameter int STEPS_W     = 16,
  parameter int PERIOD_W    = 24,
  parameter int POS_W       = 32,
  parameter int MIN_PERIOD  = 1000,
  parameter int MAX_PERIOD  = 1000000,
  parameter int HOLD_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic                cmd_dir,
  input  logic                cmd_half,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [3:0]          drive_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [POS_W-1:0]    position,
  output logic [2:0]          phase_idx
);

  // One timer serves both the step period and the hold time.
  localparam int TIMER_MAX = (MAX_PERIOD > HOLD_CYCLES) ? MAX_PERIOD : HOLD_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P     = PERIOD_W'(MAX_PERIOD);
  localparam logic [TIMER_W-1:0]  HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } stateT;

  stateT                     state;
  logic [TIMER_W-1:0]        timer;
  logic [TIMER_W-1:0]        runReload;
  logic [STEPS_W-1:0]        remaining;
  logic                      runDir;
  logic                      runHalf;
  logic [3:0]                driveReg;
  logic [2:0]                phaseIdx;
  logic signed [POS_W-1:0]   posReg;
  logic                      doneReg;
  logic                      abortedReg;
  logic                      busyReg;

  logic                      accept;
  logic                      startNow;
  logic                      stepDir;
  logic                      stepHalf;
  logic [1:0]                stepMag;
  logic [2:0]                nextIdx;
  logic signed [POS_W-1:0]   stepDelta;
  logic signed [POS_W-1:0]   nextPos;
  logic [PERIOD_W-1:0]       periodClamped;

  function automatic logic [PERIOD_W-1:0] clampPeriod(input logic [PERIOD_W-1:0] raw);
    logic [PERIOD_W-1:0] res;
    res = raw;
    if (raw < MIN_P) res = MIN_P;
    else if (raw > MAX_P) res = MAX_P;
    return res;
  endfunction

  function automatic logic [3:0] coilPattern(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b0001;
      3'd1:    pat = 4'b0011;
      3'd2:    pat = 4'b0010;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0100;
      3'd5:    pat = 4'b1100;
      3'd6:    pat = 4'b1000;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Full-step from an even (single-coil) entry moves 1 so it lands on a
  // two-phase entry; from there on it moves 2 to stay on two-phase entries.
  function automatic logic [1:0] stepSize(input logic [2:0] idx, input logic half);
    logic [1:0] sz;
    if (half) sz = 2'd1;
    else if (idx[0]) sz = 2'd2;
    else sz = 2'd1;
    return sz;
  endfunction

  // A command may start from IDLE or HOLD, never while a step is in progress;
  // abort and reset both block acceptance.
  assign cmd_ready     = rst_n && !abort && (state != RUN);
  assign accept        = cmd_valid && cmd_ready;
  assign startNow      = accept && (cmd_steps != '0);
  assign periodClamped = clampPeriod(cmd_period);

  // Next table index and position for a step, using the new command's
  // direction/mode when starting and the latched ones while running.
  always_comb begin
    stepDir  = runDir;
    stepHalf = runHalf;
    if (state != RUN) begin
      stepDir  = cmd_dir;
      stepHalf = cmd_half;
    end
    stepMag   = stepSize(phaseIdx, stepHalf);
    nextIdx   = stepDir ? (phaseIdx + {1'b0, stepMag}) : (phaseIdx - {1'b0, stepMag});
    stepDelta = POS_W'(stepMag);
    if (!stepDir) stepDelta = -stepDelta;
    nextPos   = posReg + stepDelta;
  end

  // Sequencer FSM: accept/abort handling, step timing, hold and de-energize.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      remaining  <= '0;
      driveReg   <= 4'b0000;
      phaseIdx   <= 3'd0;
      posReg     <= '0;
      doneReg    <= 1'b0;
      abortedReg <= 1'b0;
      busyReg    <= 1'b0;
    end else begin
      doneReg    <= 1'b0;
      abortedReg <= 1'b0;
      if (startNow) begin
        // First step goes out with the accept; a HOLD is taken over silently.
        state     <= RUN;
        busyReg   <= 1'b1;
        phaseIdx  <= nextIdx;
        driveReg  <= coilPattern(nextIdx);
        posReg    <= nextPos;
        timer     <= TIMER_W'(periodClamped - PERIOD_W'(1));
        runReload <= TIMER_W'(periodClamped - PERIOD_W'(1));
        remaining <= cmd_steps - STEPS_W'(1);
        runDir    <= cmd_dir;
        runHalf   <= cmd_half;
      end else if (abort && (state != IDLE)) begin
        state      <= IDLE;
        busyReg    <= 1'b0;
        driveReg   <= 4'b0000;
        doneReg    <= 1'b1;
        abortedReg <= 1'b1;
      end else begin
        // Zero-step command: report completion, leave motion state alone.
        if (accept) doneReg <= 1'b1;
        unique case (state)
          RUN: begin
            if (timer == '0) begin
              if (remaining != '0) begin
                phaseIdx  <= nextIdx;
                driveReg  <= coilPattern(nextIdx);
                posReg    <= nextPos;
                timer     <= runReload;
                remaining <= remaining - STEPS_W'(1);
              end else begin
                state <= HOLD;
                timer <= HOLD_LOAD;
              end
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          HOLD: begin
            if (timer == '0) begin
              state    <= IDLE;
              busyReg  <= 1'b0;
              driveReg <= 4'b0000;
              doneReg  <= 1'b1;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign drive_out = driveReg;
  assign busy      = busyReg;
  assign done      = doneReg;
  assign aborted   = abortedReg;
  assign position  = posReg;
  assign phase_idx = phaseIdx;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer with shortened period/hold parameters.
module tb_stepper_sequencer;

  localparam int MINP  = 20;
  localparam int MAXP  = 200;
  localparam int HOLDC = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic        cmd_half = 1'b0;
  logic [23:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic [3:0]  drive_out;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] position;
  logic [2:0]  phase_idx;

  int passCnt = 0;
  int totalCnt = 0;

  logic [3:0] expPat [4];
  int         expIdx [4];
  int         expPos [4];

  always #5 clk = ~clk;

  stepper_sequencer #(
    .STEPS_W(16), .PERIOD_W(24), .POS_W(32),
    .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .HOLD_CYCLES(HOLDC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
    .cmd_period(cmd_period), .abort(abort), .drive_out(drive_out),
    .busy(busy), .done(done), .aborted(aborted), .position(position),
    .phase_idx(phase_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendCmd(input int steps, input logic dir, input logic half, input int period);
    cmd_valid  = 1'b1;
    cmd_steps  = 16'(steps);
    cmd_dir    = dir;
    cmd_half   = half;
    cmd_period = 24'(period);
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    totalCnt++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else passCnt++;
    totalCnt++; if ({drive_out, phase_idx} !== 7'd0) $display("FAIL reset_drive_idx: got %b/%0d want 0000/0", drive_out, phase_idx); else passCnt++;
    totalCnt++; if (position !== 32'd0) $display("FAIL reset_pos: got %0d want 0", $signed(position)); else passCnt++;
    totalCnt++; if ({busy, done, aborted} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, aborted}); else passCnt++;
    rst_n = 1'b1;
    #1;
    totalCnt++; if (cmd_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", cmd_ready); else passCnt++;
  endtask

  // Runs one move against expPat/expIdx/expPos, checking step spacing and
  // the hold length before the completion pulse.
  task automatic test_move(input string name, input int steps, input logic dir, input logic half,
                           input int period, input int spacing);
    int n;
    int badHold;
    sendCmd(steps, dir, half, period);
    for (int k = 0; k < steps; k++) begin
      if (k > 0) begin
        repeat (spacing - 1) tick();
        totalCnt++; if (drive_out !== expPat[k-1]) $display("FAIL %s_gap%0d: got %b want %b", name, k, drive_out, expPat[k-1]); else passCnt++;
        tick();
      end
      totalCnt++; if (drive_out !== expPat[k]) $display("FAIL %s_pat%0d: got %b want %b", name, k, drive_out, expPat[k]); else passCnt++;
      totalCnt++; if (phase_idx !== 3'(expIdx[k]) || position !== 32'(expPos[k]))
        $display("FAIL %s_idxpos%0d: got %0d/%0d want %0d/%0d", name, k, phase_idx, $signed(position), expIdx[k], expPos[k]);
      else passCnt++;
    end
    badHold = 0;
    n = 0;
    for (int c = 1; c <= 2000; c++) begin
      tick();
      n = c;
      if (done) break;
      if (drive_out !== expPat[steps-1] || busy !== 1'b1) badHold++;
    end
    totalCnt++; if (n !== spacing + HOLDC) $display("FAIL %s_done_time: got %0d want %0d", name, n, spacing + HOLDC); else passCnt++;
    totalCnt++; if (badHold !== 0) $display("FAIL %s_hold_pat: got %0d bad cycles want 0", name, badHold); else passCnt++;
    totalCnt++; if ({drive_out, done, aborted, busy} !== 7'b0000_100) $display("FAIL %s_end: got %b want 0000100", name, {drive_out, done, aborted, busy}); else passCnt++;
    totalCnt++; if (position !== 32'(expPos[steps-1])) $display("FAIL %s_end_pos: got %0d want %0d", name, $signed(position), expPos[steps-1]); else passCnt++;
    tick();
    totalCnt++; if (done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", name, done); else passCnt++;
  endtask

  task automatic test_full_fwd();
    expPat = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    expIdx = '{1, 3, 5, 7};
    expPos = '{1, 3, 5, 7};
    test_move("full_fwd", 4, 1'b1, 1'b0, 20, MINP);
  endtask

  task automatic test_half_rev_clamp();
    expPat = '{4'b1000, 4'b1100, 4'b0100, 4'b0000};
    expIdx = '{6, 5, 4, 0};
    expPos = '{6, 5, 4, 0};
    test_move("half_rev", 3, 1'b0, 1'b1, 5, MINP);
  endtask

  task automatic test_max_clamp_wrap();
    expPat = '{4'b1100, 4'b1000, 4'b1001, 4'b0001};
    expIdx = '{5, 6, 7, 0};
    expPos = '{5, 6, 7, 8};
    test_move("max_wrap", 4, 1'b1, 1'b1, 5000, MAXP);
  endtask

  task automatic test_reverse_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expPat = '{4'b1001, 4'b0000, 4'b0000, 4'b0000};
    expIdx = '{7, 0, 0, 0};
    expPos = '{-1, 0, 0, 0};
    test_move("rev_wrap", 1, 1'b0, 1'b0, 20, MINP);
  endtask

  task automatic test_abort();
    // From idx 7, position -1: full forward gives idx 1,3,5 and position 1,3,5.
    sendCmd(10, 1'b1, 1'b0, 20);
    repeat (49) tick();
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_steps = 16'd5;
    #1;
    totalCnt++; if (cmd_ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", cmd_ready); else passCnt++;
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    totalCnt++; if ({drive_out, done, aborted, busy} !== 7'b0000_110) $display("FAIL abort_flags: got %b want 0000110", {drive_out, done, aborted, busy}); else passCnt++;
    totalCnt++; if (position !== 32'd5 || phase_idx !== 3'd5) $display("FAIL abort_pos: got %0d/%0d want 5/5", $signed(position), phase_idx); else passCnt++;
    tick();
    totalCnt++; if ({drive_out, done, busy} !== 6'b0000_00) $display("FAIL abort_not_accepted: got %b want 000000", {drive_out, done, busy}); else passCnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    totalCnt++; if ({done, busy, drive_out} !== 6'd0) $display("FAIL abort_idle: got %b want 000000", {done, busy, drive_out}); else passCnt++;
  endtask

  task automatic test_back_to_back();
    int zeroCnt;
    int doneCnt;
    int n;
    zeroCnt = 0;
    doneCnt = 0;
    // Move A: half forward from idx 5 -> 6, 7 (position 7); hold starts 40 cycles in.
    sendCmd(2, 1'b1, 1'b1, 20);
    for (int c = 0; c < 69; c++) begin
      tick();
      if (drive_out === 4'b0000) zeroCnt++;
      if (done === 1'b1) doneCnt++;
    end
    // Move B during the hold: full forward from idx 7 -> 1, 3 (position 11).
    cmd_valid = 1'b1;
    cmd_steps = 16'd2;
    cmd_dir = 1'b1;
    cmd_half = 1'b0;
    cmd_period = 24'd20;
    #1;
    totalCnt++; if (cmd_ready !== 1'b1 || busy !== 1'b1) $display("FAIL b2b_hold_ready: got %b%b want 11", cmd_ready, busy); else passCnt++;
    tick();
    cmd_valid = 1'b0;
    totalCnt++; if (drive_out !== 4'b0011 || position !== 32'd9) $display("FAIL b2b_first: got %b/%0d want 0011/9", drive_out, $signed(position)); else passCnt++;
    n = 0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      n = c;
      if (done === 1'b1) doneCnt++;
      if (busy !== 1'b1) break;
      if (drive_out === 4'b0000) zeroCnt++;
    end
    repeat (3) begin
      tick();
      if (done === 1'b1) doneCnt++;
    end
    totalCnt++; if (n !== 140) $display("FAIL b2b_time: got %0d want 140", n); else passCnt++;
    totalCnt++; if (zeroCnt !== 0) $display("FAIL b2b_zero_gap: got %0d want 0", zeroCnt); else passCnt++;
    totalCnt++; if (doneCnt !== 1) $display("FAIL b2b_done_count: got %0d want 1", doneCnt); else passCnt++;
    totalCnt++; if (position !== 32'd11 || phase_idx !== 3'd3) $display("FAIL b2b_pos: got %0d/%0d want 11/3", $signed(position), phase_idx); else passCnt++;
  endtask

  task automatic test_zero_steps();
    sendCmd(0, 1'b1, 1'b0, 20);
    totalCnt++; if ({done, aborted, busy, drive_out} !== 7'b100_0000) $display("FAIL zero_done: got %b want 1000000", {done, aborted, busy, drive_out}); else passCnt++;
    totalCnt++; if (position !== 32'd11) $display("FAIL zero_pos: got %0d want 11", $signed(position)); else passCnt++;
    tick();
    totalCnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_pulse: got %b%b want 00", done, busy); else passCnt++;
  endtask

  task automatic test_reset_mid_run();
    int doneSeen;
    doneSeen = 0;
    sendCmd(5, 1'b1, 1'b1, 20);
    totalCnt++; if (drive_out !== 4'b0100 || position !== 32'd12) $display("FAIL mid_start: got %b/%0d want 0100/12", drive_out, $signed(position)); else passCnt++;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    totalCnt++; if (cmd_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", cmd_ready); else passCnt++;
    repeat (3) begin
      tick();
      if (done === 1'b1) doneSeen++;
    end
    totalCnt++; if ({drive_out, phase_idx, busy, aborted} !== 9'd0 || position !== 32'd0) $display("FAIL mid_rst_vals: got %b/%0d/%b%b/%0d want 0000/0/00/0", drive_out, phase_idx, busy, aborted, $signed(position)); else passCnt++;
    totalCnt++; if (doneSeen !== 0) $display("FAIL mid_rst_done: got %0d want 0", doneSeen); else passCnt++;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_fwd();
    test_half_rev_clamp();
    test_max_clamp_wrap();
    test_reverse_wrap();
    test_abort();
    test_back_to_back();
    test_zero_steps();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
